dct_input_butterfly: RTL and testbench

DCT_INPUT_BUTTERFLY -- requirements
Module: dct_input_butterfly

---
 rtl/dct_pkg.sv | 10 +
 rtl/dct_butterfly_pair.sv | 20 ++
 rtl/dct_input_butterfly.sv | 86 ++++++++
 tb/tb_dct_input_butterfly.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// Shared constants and index types for the 8-point DCT datapath.
package dct_pkg;

    localparam int DCT_N    = 8;
    localparam int DCT_HALF = 4;

    typedef logic       bank_t;
    typedef logic [2:0] idx_t;

endpackage

// File: rtl/dct_butterfly_pair.sv
// One input butterfly lane: exact sum and difference of two signed samples.
module dct_butterfly_pair #(
    parameter int WIDTH = 8
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH:0]   sum,
    output logic signed [WIDTH:0]   diff
);

    logic signed [WIDTH:0] a_ext;
    logic signed [WIDTH:0] b_ext;

    // One guard bit makes both results exact for any pair of inputs.
    assign a_ext = {a[WIDTH-1], a};
    assign b_ext = {b[WIDTH-1], b};
    assign sum   = a_ext + b_ext;
    assign diff  = a_ext - b_ext;

endmodule

// File: rtl/dct_input_butterfly.sv
// Ping-pong sample buffer feeding four butterfly lanes; one block of 8 samples per result.
module dct_input_butterfly
    import dct_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = DCT_N
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DCT_HALF*(WIDTH+1)-1:0]  out_sum,
    output logic [DCT_HALF*(WIDTH+1)-1:0]  out_diff
);

    localparam idx_t IDX_LAST = idx_t'(N - 1);

    logic signed [WIDTH-1:0] mem [2][N];
    logic [1:0]              full;
    logic [1:0]              full_nxt;
    bank_t                   wr_bank;
    bank_t                   rd_bank;
    idx_t                    wr_idx;
    logic                    in_fire;
    logic                    in_last;
    logic                    out_fire;

    assign in_ready  = !full[wr_bank];
    assign out_valid = full[rd_bank];
    assign in_fire   = in_valid && in_ready;
    assign in_last   = in_fire && (wr_idx == IDX_LAST);
    assign out_fire  = out_valid && out_ready;

    // Fill and drain always target different banks, so both updates can apply together.
    always_comb begin
        full_nxt = full;
        if (in_last) begin
            full_nxt[wr_bank] = 1'b1;
        end
        if (out_fire) begin
            full_nxt[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full    <= 2'b00;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_idx  <= '0;
        end else begin
            full <= full_nxt;
            if (in_fire) begin
                wr_idx <= wr_idx + idx_t'(1);
                if (in_last) begin
                    wr_bank <= ~wr_bank;
                end
            end
            if (out_fire) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

    // Sample storage carries no reset; the full flags alone qualify its contents.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            mem[wr_bank][wr_idx] <= in_data;
        end
    end

    for (genvar k = 0; k < DCT_HALF; k++) begin : g_lane
        dct_butterfly_pair #(
            .WIDTH (WIDTH)
        ) u_pair (
            .a    (mem[rd_bank][k]),
            .b    (mem[rd_bank][N-1-k]),
            .sum  (out_sum[k*(WIDTH+1) +: (WIDTH+1)]),
            .diff (out_diff[k*(WIDTH+1) +: (WIDTH+1)])
        );
    end

endmodule

// File: tb/tb_dct_input_butterfly.sv
// Self-checking bench for dct_input_butterfly: vector table, stall/throughput/reset sequences, random scoreboard run.
module tb_dct_input_butterfly;

    localparam int W  = 8;
    localparam int VW = 4 * (W + 1);

    typedef struct packed {
        logic [7:0][W-1:0] x;
        logic [3:0][W:0]   s;
        logic [3:0][W:0]   d;
    } vec_t;

    typedef struct packed {
        logic [VW-1:0] s;
        logic [VW-1:0] d;
    } res_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] out_sum;
    logic [VW-1:0] out_diff;

    always #5 clk = ~clk;

    dct_input_butterfly #(.WIDTH(W), .N(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_diff  (out_diff)
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic check_int(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic res_t model(input int x[8]);
        res_t r;
        for (int k = 0; k < 4; k++) begin
            r.s[k*(W+1) +: (W+1)] = 9'(x[k] + x[7-k]);
            r.d[k*(W+1) +: (W+1)] = 9'(x[k] - x[7-k]);
        end
        return r;
    endfunction

    // Scoreboard monitor: observes transfers at the negedge, before the edge that commits them.
    res_t          sb[$];
    int            mbuf[8];
    int            mcnt   = 0;
    int            pushed = 0;
    int            popped = 0;
    int            cyc    = 0;
    int            out_cyc[$];
    logic          stall_q = 1'b0;
    logic [VW-1:0] hold_s;
    logic [VW-1:0] hold_d;

    always @(negedge clk) begin
        res_t r;
        cyc++;
        if (rst) begin
            mcnt    = 0;
            stall_q = 1'b0;
            sb.delete();
        end else begin
            if (stall_q) begin
                check_int("stall_out_valid", int'(out_valid), 1);
                check_vec("stall_out_sum", out_sum, hold_s);
                check_vec("stall_out_diff", out_diff, hold_d);
            end
            if (out_valid && out_ready) begin
                out_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_result: got out_sum %h, expected no result", out_sum);
                end else begin
                    r = sb.pop_front();
                    popped++;
                    check_vec("sb_sum", out_sum, r.s);
                    check_vec("sb_diff", out_diff, r.d);
                end
            end
            if (in_valid && in_ready) begin
                mbuf[mcnt] = int'($signed(in_data));
                mcnt++;
                if (mcnt == 8) begin
                    sb.push_back(model(mbuf));
                    pushed++;
                    mcnt = 0;
                end
            end
            stall_q = out_valid && !out_ready;
            hold_s  = out_sum;
            hold_d  = out_diff;
        end
    end

    task automatic send(input logic [W-1:0] d, input logic ordy);
        int   n;
        logic acc;
        n         = 0;
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = ordy;
        do begin
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) begin
            compared++;
            mismatched++;
            $display("FAIL send_timeout: got in_ready 0 for %0d cycles, expected acceptance", n);
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n, input logic ordy);
        in_valid  = 1'b0;
        out_ready = ordy;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    vec_t          tbl[6];
    int            tx[8];
    int            ts[4];
    int            td[4];
    logic [W-1:0]  blk[3][8];

    function automatic vec_t mk(input int x[8], input int s[4], input int d[4]);
        vec_t v;
        for (int i = 0; i < 8; i++) v.x[i] = 8'(x[i]);
        for (int k = 0; k < 4; k++) begin
            v.s[k] = 9'(s[k]);
            v.d[k] = 9'(d[k]);
        end
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int b0;
        int lowcnt;
        int guard;

        tx = '{1, 2, 3, 4, 5, 6, 7, 8};            ts = '{9, 9, 9, 9};         td = '{-7, -5, -3, -1};
        tbl[0] = mk(tx, ts, td);
        tx = '{-128, -128, -128, -128, -128, -128, -128, -128};
        ts = '{-256, -256, -256, -256};            td = '{0, 0, 0, 0};
        tbl[1] = mk(tx, ts, td);
        tx = '{127, 127, 127, 127, 127, 127, 127, 127};
        ts = '{254, 254, 254, 254};                td = '{0, 0, 0, 0};
        tbl[2] = mk(tx, ts, td);
        tx = '{127, 0, 0, 0, 0, 0, 0, -128};       ts = '{-1, 0, 0, 0};        td = '{255, 0, 0, 0};
        tbl[3] = mk(tx, ts, td);
        tx = '{10, -20, 30, -40, 50, -60, 70, -80}; ts = '{-70, 50, -30, 10};  td = '{90, -90, 90, -90};
        tbl[4] = mk(tx, ts, td);
        tx = '{-128, -128, 0, 0, 0, 0, -128, 127}; ts = '{-1, -256, 0, 0};     td = '{-255, 0, 0, 0};
        tbl[5] = mk(tx, ts, td);

        // in_valid held high through reset must not load anything
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h55;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        check_int("reset_in_ready", int'(in_ready), 1);
        check_int("reset_out_valid", int'(out_valid), 0);

        for (int t = 0; t < 6; t++) begin
            for (int j = 0; j < 8; j++) send(tbl[t].x[j], 1'b1);
            check_int($sformatf("tbl%0d_latency_out_valid", t), int'(out_valid), 1);
            check_vec($sformatf("tbl%0d_sum", t), out_sum, tbl[t].s);
            check_vec($sformatf("tbl%0d_diff", t), out_diff, tbl[t].d);
        end
        idle(3, 1'b1);

        // Backpressure: both banks fill, input stalls, then three blocks drain in order
        p0 = popped;
        for (int b = 0; b < 3; b++)
            for (int j = 0; j < 8; j++) blk[b][j] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 16; i++) begin
            check_int($sformatf("bp_in_ready_%0d", i), int'(in_ready), 1);
            send(blk[i/8][i%8], 1'b0);
        end
        check_int("bp_in_ready_low", int'(in_ready), 0);
        check_int("bp_out_valid", int'(out_valid), 1);
        in_valid = 1'b1;
        in_data  = blk[2][0];
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        check_int("bp_still_stalled", int'(in_ready), 0);
        for (int j = 0; j < 8; j++) send(blk[2][j], 1'b1);
        idle(5, 1'b1);
        check_int("bp_blocks_out", popped - p0, 3);
        check_int("bp_sb_empty", sb.size(), 0);

        // Sustained streaming: no bubbles, one result every 8 cycles
        out_cyc.delete();
        lowcnt    = 0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            in_data = 8'($urandom_range(0, 255));
            if (!in_ready) lowcnt++;
            @(posedge clk);
            #1;
        end
        idle(2, 1'b1);
        check_int("stream_in_ready_low_cycles", lowcnt, 0);
        check_int("stream_results", out_cyc.size(), 8);
        for (int i = 1; i < out_cyc.size(); i++)
            check_int($sformatf("stream_gap_%0d", i), out_cyc[i] - out_cyc[i-1], 8);

        // Reset mid-block discards the partial block
        for (int j = 0; j < 5; j++) send(8'(j + 100), 1'b1);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h7f;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        check_int("mid_rst_in_ready", int'(in_ready), 1);
        p0 = popped;
        for (int j = 0; j < 8; j++) begin
            check_int($sformatf("mid_rst_no_valid_%0d", j), int'(out_valid), 0);
            send(8'(j * 17 - 60), 1'b1);
        end
        check_int("mid_rst_out_valid", int'(out_valid), 1);
        idle(2, 1'b1);
        check_int("mid_rst_blocks", popped - p0, 1);

        // Random handshake toggling over 1000 blocks
        p0    = popped;
        b0    = pushed;
        guard = 0;
        while ((pushed - b0) < 1000 && guard < 60000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom_range(0, 255));
            out_ready = ($urandom_range(0, 1) != 0);
            @(posedge clk);
            #1;
            guard++;
        end
        idle(30, 1'b1);
        check_int("rand_blocks_in", pushed - b0, 1000);
        check_int("rand_blocks_out", popped - p0, pushed - b0);
        check_int("rand_sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
